alu_z_writeback: RTL and testbench
==================================

// Module: alu_z_writeback
// PURPOSE
//  Downstream stage of the ALU: captures each ALU result (Zlowout/Zhighout plus op and destination) into a
//  small FIFO and sequences it back to the register file over a 32-bit valid/ready write-back port.
//  Wide ops (MUL 5'b01111, DIV 5'b10000) produce two beats: LO (Zlow), then HI (Zhigh); all others produce one beat.
//  Decouples ALU issue from register-file port contention.
// PARAMETERS
//  DEPTH  2  FIFO entries; power of two, >=2
// PORTS
//  clock     in   1   single clock; all state updates on posedge
//  clear_n   in   1   synchronous active-low reset, sampled on posedge clock
//  in_valid  in   1   ALU result valid this cycle
//  in_ready  out  1   stage can accept a result (FIFO not full)
//  op        in   5   ALU opcode of the result
//  rd        in   4   destination GPR index
//  Zlowout   in   32  ALU result bits [31:0]
//  Zhighout  in   32  ALU result bits [63:32]
//  wb_valid  out  1   write-back beat valid
//  wb_ready  in   1   register file accepts beat
//  wb_dest   out  5   {1'b0,rd} for GPR; 5'd16 = LO; 5'd17 = HI
//  wb_data   out  32  write-back data
//  wb_last   out  1   final beat of the current entry
//  busy      out  1   FIFO non-empty or beat pending
// BEHAVIOUR
//  - Reset (clear_n=0 at posedge): count=0, pointers=0, FSM=IDLE, all outputs 0 except in_ready=1 (first cycle after reset).
//    Reset mid-sequence discards all entries, including a half-written wide op; no further beats are emitted.
//  - Push: in_valid&&in_ready at a posedge writes {op,rd,Zlowout,Zhighout}. Pointers wrap modulo DEPTH.
//  - in_ready = (count!=DEPTH) and depends on registered count only. There is no same-cycle bypass:
//    when the FIFO is full, in_ready stays 0 in the cycle the head pops.
//  - Latency: an entry pushed into an empty FIFO at edge N drives wb_valid=1 after edge N+1. One idle cycle minimum.
//  - FSM states:
//    IDLE: go to BEAT0 when count!=0.
//    BEAT0 (head): narrow op -> dest={0,rd}, data=lo, last=1. Wide op -> dest=16, data=lo, last=0.
//    BEAT0 on handshake: narrow -> pop, then BEAT0 if more entries remain, else IDLE. Wide -> BEAT1.
//    BEAT1: dest=17, data=hi, last=1. On handshake: pop, then BEAT0 if more entries remain, else IDLE.
//  - wb_valid, wb_dest, wb_data and wb_last stay stable while wb_valid && !wb_ready. Beats are never withdrawn.
//  - Push and pop in the same cycle: count unchanged. Both pointers advance.
//  - rd is passed through verbatim, including rd=0. The register file owns r0 semantics.
//  - Unknown or non-wide opcodes are treated as narrow.
// CONFIGURATION
//  ALU_Z_FLAGS_EN defined:
//   - Each entry also stores flags computed at push time.
//   - z = (lo==0) && (wide ? hi==0 : 1).
//   - n = wide ? hi[31] : lo[31].
//   - Outputs flag_z and flag_n (1 bit each) load from the head entry on the last-beat handshake and hold otherwise.
//   - flag_z and flag_n reset to 0.
//  ALU_Z_FLAGS_EN undefined: no flag storage and no flag ports.
// STRUCTURE
//  - Package alu_pkg:
//    - OP_MUL=5'b01111, OP_DIV=5'b10000
//    - DEST_LO=5'd16, DEST_HI=5'd17
//    - typedef z_entry_t {op,rd,lo,hi[,z,n]}
//    - typedef wb_state_t {IDLE,BEAT0,BEAT1}
//  - Sub-module z_fifo: synchronous FIFO holding z_entry_t with push/pop, count, full/empty.
//  - Top level: holds the write-back FSM and the output mux.
// TESTING
//  1. ADD (op 5'b00011), rd=3, Zlow=32'h0000_0005, wb_ready=1
//     -> one beat two cycles after push: dest=3, data=5, last=1; busy then falls.
//  2. MUL, rd=2, Zlow=32'hDEAD_BEEF, Zhigh=32'h0000_0012, wb_ready=1
//     -> beats dest=16/data=DEADBEEF/last=0, then dest=17/data=00000012/last=1.
//  3. wb_ready=0 while 3 pushes are attempted (DEPTH=2)
//     -> in_ready=0 after 2 pushes; the third is not accepted; wb outputs remain stable.
//     -> Releasing wb_ready drains both entries in order.
//  4. DIV in flight, clear_n=0 after the LO beat handshake
//     -> no HI beat; wb_valid=0, busy=0, in_ready=1 after reset.
//  5. Back-to-back narrow pushes every cycle with wb_ready=1
//     -> sustained one beat per cycle; order is preserved across pointer wrap (at least 5 entries).
//  6. [ALU_Z_FLAGS_EN] SUB giving Zlow=0 -> flag_z=1, flag_n=0; MUL giving Zhigh=32'h8000_0000 -> flag_z=0, flag_n=1.

Source files
------------

// File: rtl/alu_z_writeback_pkg.sv
// Shared types for the ALU result write-back stage: opcodes, write-back destinations, FIFO entry, FSM states.
// Build option ALU_Z_FLAGS_EN adds precomputed z/n flags to each entry.
package alu_pkg;

    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] DEST_LO = 5'd16;
    localparam logic [4:0] DEST_HI = 5'd17;

    typedef struct packed {
        logic [4:0]  op;
        logic [3:0]  rd;
        logic [31:0] lo;
        logic [31:0] hi;
`ifdef ALU_Z_FLAGS_EN
        logic        z;
        logic        n;
`endif
    } z_entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2
    } wb_state_t;

    // Only MUL and DIV carry a meaningful high word; anything else is a single beat.
    function automatic logic is_wide(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_z_writeback_if.sv
// ALU-result input and register-file write-back port of the write-back stage.
// Build option ALU_Z_FLAGS_EN adds the flag_z/flag_n outputs.
interface alu_z_writeback_if;

    logic        in_valid;
    logic        in_ready;
    logic [4:0]  op;
    logic [3:0]  rd;
    logic [31:0] Zlowout;
    logic [31:0] Zhighout;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_dest;
    logic [31:0] wb_data;
    logic        wb_last;
    logic        busy;
`ifdef ALU_Z_FLAGS_EN
    logic        flag_z;
    logic        flag_n;
`endif

    modport master (
        output in_valid, op, rd, Zlowout, Zhighout, wb_ready,
        input  in_ready, wb_valid, wb_dest, wb_data, wb_last, busy
`ifdef ALU_Z_FLAGS_EN
        , input flag_z, flag_n
`endif
    );

    modport slave (
        input  in_valid, op, rd, Zlowout, Zhighout, wb_ready,
        output in_ready, wb_valid, wb_dest, wb_data, wb_last, busy
`ifdef ALU_Z_FLAGS_EN
        , output flag_z, flag_n
`endif
    );

endinterface

// File: rtl/alu_z_writeback_z_fifo.sv
// Synchronous FIFO of z_entry_t; head is a registered read, valid whenever o_empty is low.
// Latency: one cycle push-to-head; caller must not push when full nor pop when empty.
module z_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clock,
    input  logic                   clear_n,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  z_entry_t               i_wdat,
    output z_entry_t               o_head,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    z_entry_t        r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clock) begin
        if (!clear_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_wdat;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (i_push && !i_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!i_push && i_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/alu_z_writeback.sv
// ALU result write-back: queues results and replays them as 1 (narrow) or 2 (MUL/DIV LO,HI) 32-bit beats.
// Latency: push into empty queue at edge N gives wb_valid after edge N+1; in_ready is !full with no pop bypass.
// Backpressure: beats hold stable under wb_ready=0. Build option ALU_Z_FLAGS_EN adds flag_z/flag_n.
module alu_z_writeback
    import alu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic             clock,
    input  logic             clear_n,
    alu_z_writeback_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = (AW+1)'(1);

    z_entry_t    w_in_entry;
    z_entry_t    w_head;
    logic [AW:0] w_count;
    logic        w_full;
    logic        w_empty;
    logic        w_push;
    logic        w_pop;
    logic        w_hs;
    logic        w_wide;
    logic        w_last;
    logic        w_more;
    wb_state_t   r_state;

    always_comb begin
        w_in_entry    = '0;
        w_in_entry.op = bus.op;
        w_in_entry.rd = bus.rd;
        w_in_entry.lo = bus.Zlowout;
        w_in_entry.hi = bus.Zhighout;
`ifdef ALU_Z_FLAGS_EN
        w_in_entry.z  = (bus.Zlowout == '0) && (is_wide(bus.op) ? (bus.Zhighout == '0) : 1'b1);
        w_in_entry.n  = is_wide(bus.op) ? bus.Zhighout[31] : bus.Zlowout[31];
`endif
    end

    z_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock   (clock),
        .clear_n (clear_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdat  (w_in_entry),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign bus.in_ready = !w_full;
    assign w_push       = bus.in_valid && !w_full;
    assign w_hs         = bus.wb_valid && bus.wb_ready;
    assign w_wide       = is_wide(w_head.op);
    assign w_last       = (r_state == BEAT1) || ((r_state == BEAT0) && !w_wide);
    assign w_pop        = w_hs && w_last;
    // After popping the head, another entry exists if one was behind it or one lands this edge.
    assign w_more       = (w_count > ONE) || w_push;

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_empty) r_state <= BEAT0;
                end
                BEAT0: begin
                    if (w_hs) begin
                        if (w_wide) r_state <= BEAT1;
                        else        r_state <= w_more ? BEAT0 : IDLE;
                    end
                end
                BEAT1: begin
                    if (w_hs) r_state <= w_more ? BEAT0 : IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Outputs decode registered state and the registered FIFO head, so they cannot move under a stall.
    always_comb begin
        bus.wb_valid = 1'b0;
        bus.wb_dest  = '0;
        bus.wb_data  = '0;
        bus.wb_last  = 1'b0;
        case (r_state)
            BEAT0: begin
                bus.wb_valid = 1'b1;
                bus.wb_dest  = w_wide ? DEST_LO : {1'b0, w_head.rd};
                bus.wb_data  = w_head.lo;
                bus.wb_last  = !w_wide;
            end
            BEAT1: begin
                bus.wb_valid = 1'b1;
                bus.wb_dest  = DEST_HI;
                bus.wb_data  = w_head.hi;
                bus.wb_last  = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.busy = !w_empty || bus.wb_valid;

`ifdef ALU_Z_FLAGS_EN
    logic r_flag_z;
    logic r_flag_n;

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            r_flag_z <= 1'b0;
            r_flag_n <= 1'b0;
        end else if (w_pop) begin
            r_flag_z <= w_head.z;
            r_flag_n <= w_head.n;
        end
    end

    assign bus.flag_z = r_flag_z;
    assign bus.flag_n = r_flag_n;
`endif

endmodule

// File: tb/tb_alu_z_writeback.sv
// Scoreboard bench for alu_z_writeback: directed pushes queue hand-derived beats, a negedge monitor checks them.
module tb_alu_z_writeback;

    logic clock   = 1'b0;
    logic clear_n = 1'b0;
    always #5 clock = ~clock;

    alu_z_writeback_if bus();

    alu_z_writeback #(.DEPTH(2)) dut (
        .clock   (clock),
        .clear_n (clear_n),
        .bus     (bus)
    );

    typedef struct {
        logic [4:0]  dest;
        logic [31:0] data;
        logic        last;
    } beat_t;

    beat_t exp_q[$];
    int    checks  = 0;
    int    errors  = 0;
    bit    measure = 0;
    int    gaps    = 0;
    bit    stalled = 0;
    beat_t held;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model: MUL (01111) and DIV (10000) give LO to 16 then HI to 17; others one beat to {0,rd}.
    task automatic expect_entry(input logic [4:0] op, input logic [3:0] rd,
                                input logic [31:0] lo, input logic [31:0] hi);
        beat_t b;
        if (op == 5'b01111 || op == 5'b10000) begin
            b.dest = 5'd16; b.data = lo; b.last = 1'b0; exp_q.push_back(b);
            b.dest = 5'd17; b.data = hi; b.last = 1'b1; exp_q.push_back(b);
        end else begin
            b.dest = {1'b0, rd}; b.data = lo; b.last = 1'b1; exp_q.push_back(b);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [4:0] op, input logic [3:0] rd, input logic [31:0] lo,
                        input logic [31:0] hi, input int tries, output bit acc);
        acc          = 1'b0;
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.rd       = rd;
        bus.Zlowout  = lo;
        bus.Zhighout = hi;
        for (int t = 0; t < tries && !acc; t++) begin
            acc = bus.in_ready;
            tick();
        end
        bus.in_valid = 1'b0;
        if (acc) expect_entry(op, rd, lo, hi);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || bus.busy) && n < budget) begin
            tick();
            n++;
        end
        check("drain_pending", exp_q.size(), 0);
        check("drain_busy", bus.busy, 0);
    endtask

    always @(negedge clock) begin
        beat_t e;
        if (!clear_n) begin
            stalled = 0;
        end else begin
            if (stalled) begin
                check("hold_valid", bus.wb_valid, 1);
                check("hold_dest", bus.wb_dest, held.dest);
                check("hold_data", bus.wb_data, held.data);
                check("hold_last", bus.wb_last, held.last);
            end
            if (measure && exp_q.size() != 0 && !bus.wb_valid) gaps++;
            if (bus.wb_valid && bus.wb_ready) begin
                stalled = 0;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got dest %0d data %h, expected no beat",
                             bus.wb_dest, bus.wb_data);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_dest", bus.wb_dest, e.dest);
                    check("beat_data", bus.wb_data, e.data);
                    check("beat_last", bus.wb_last, e.last);
                end
            end else if (bus.wb_valid) begin
                stalled   = 1;
                held.dest = bus.wb_dest;
                held.data = bus.wb_data;
                held.last = bus.wb_last;
            end else begin
                stalled = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit a1, a2, a3;
        bus.in_valid = 1'b0;
        bus.op       = '0;
        bus.rd       = '0;
        bus.Zlowout  = '0;
        bus.Zhighout = '0;
        bus.wb_ready = 1'b0;
        clear_n      = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_wb_valid", bus.wb_valid, 0);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_wb_dest", bus.wb_dest, 0);
        check("rst_wb_data", bus.wb_data, 0);
        check("rst_wb_last", bus.wb_last, 0);
        clear_n = 1'b1;
        tick();

        // 1: narrow ADD, latency and busy fall
        bus.wb_ready = 1'b1;
        push(5'b00011, 4'd3, 32'h0000_0005, 32'h0, 1, a1);
        check("t1_accept", a1, 1);
        check("t1_valid_edgeN", bus.wb_valid, 0);
        check("t1_busy_edgeN", bus.busy, 1);
        tick();
        check("t1_valid_edgeN1", bus.wb_valid, 1);
        tick();
        check("t1_busy_after", bus.busy, 0);
        check("t1_valid_after", bus.wb_valid, 0);

        // 2: MUL splits into LO then HI
        push(5'b01111, 4'd2, 32'hDEAD_BEEF, 32'h0000_0012, 1, a1);
        check("t2_accept", a1, 1);
        wait_drain(20);

        // 3: stalled port, third push refused, then drain in order (rd=0 passes through)
        bus.wb_ready = 1'b0;
        push(5'b00011, 4'd5, 32'h0000_0011, 32'h0, 1, a1);
        push(5'b00001, 4'd0, 32'h0000_0022, 32'h0, 1, a2);
        check("t3_in_ready_full", bus.in_ready, 0);
        push(5'b00011, 4'd9, 32'h0000_0033, 32'h0, 1, a3);
        check("t3_accept1", a1, 1);
        check("t3_accept2", a2, 1);
        check("t3_accept3", a3, 0);
        repeat (3) tick();
        check("t3_stall_valid", bus.wb_valid, 1);
        check("t3_stall_dest", bus.wb_dest, 5);
        bus.wb_ready = 1'b1;
        wait_drain(20);

        // 4: reset between LO and HI of a DIV
        bus.wb_ready = 1'b0;
        push(5'b10000, 4'd7, 32'hCAFE_0001, 32'h0000_0055, 1, a1);
        void'(exp_q.pop_back());
        tick();
        check("t4_lo_valid", bus.wb_valid, 1);
        check("t4_lo_dest", bus.wb_dest, 16);
        bus.wb_ready = 1'b1;
        tick();
        check("t4_hi_pending", bus.wb_dest, 17);
        clear_n      = 1'b0;
        bus.wb_ready = 1'b0;
        tick();
        clear_n = 1'b1;
        check("t4_wb_valid", bus.wb_valid, 0);
        check("t4_busy", bus.busy, 0);
        check("t4_in_ready", bus.in_ready, 1);
        bus.wb_ready = 1'b1;
        repeat (4) tick();
        check("t4_no_hi", exp_q.size(), 0);

        // 5: back-to-back narrow pushes, one beat per cycle across pointer wrap
        measure = 1;
        gaps    = 0;
        for (int i = 0; i < 6; i++) begin
            push(5'b00010, 4'(i + 1), 32'h0000_0100 + 32'(i), 32'h0, 4, a1);
            check("t5_accept", a1, 1);
        end
        wait_drain(20);
        measure = 0;
        check("t5_idle_cycles", gaps, 1);

`ifdef ALU_Z_FLAGS_EN
        // 6: flags load on the last beat
        push(5'b00100, 4'd1, 32'h0000_0000, 32'h0000_1234, 1, a1);
        wait_drain(20);
        check("t6_sub_z", bus.flag_z, 1);
        check("t6_sub_n", bus.flag_n, 0);
        push(5'b01111, 4'd2, 32'h0000_0001, 32'h8000_0000, 1, a1);
        wait_drain(20);
        check("t6_mul_z", bus.flag_z, 0);
        check("t6_mul_n", bus.flag_n, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
